// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl: sequences one reaction-game round. It waits a pseudo-random
// delay, lights the stimulus LED, times the press in ms, and holds the result until acked.
// Ports: clk, rst_n (async, active low); tick_1ms (1 ms strobe);
//   start (level; a rising edge starts a round); mode (difficulty);
//   btn (player button, level); stim_led (stimulus LED); busy (round in progress);
//   result_valid, result_ms, false_start, timeout (result bundle); result_ack (consumer accept).
module reaction_round_ctrl #(
    parameter int          TIME_W       = 10,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_W       = 11,
    parameter int          TIMEOUT_MS   = 999,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1ms,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              btn,
    output logic              stim_led,
    output logic              busy,
    output logic              result_valid,
    output logic [TIME_W-1:0] result_ms,
    output logic              false_start,
    output logic              timeout,
    input  logic              result_ack
);

    // Delay counter is wide enough for MIN_DELAY_MS + 2^RAND_W - 1.
    localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_W));

    localparam logic [TIME_W-1:0] LIM_EASY  = TIME_W'(TIMEOUT_MS);
    localparam logic [TIME_W-1:0] LIM_MED   = TIME_W'(TIMEOUT_MS >> 1);
    localparam logic [TIME_W-1:0] LIM_HARD  = TIME_W'(TIMEOUT_MS >> 2);
    localparam logic [DLY_W-1:0]  DLY_MIN   = DLY_W'(MIN_DELAY_MS);
    localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        GO,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic              start_q;
    logic              btn_q;
    logic              start_rise;
    logic              btn_rise;
    logic [15:0]       lfsr;
    logic [DLY_W-1:0]  delay_cnt;
    logic [DLY_W-1:0]  delay_nx;
    logic [TIME_W-1:0] ms_cnt;
    logic [TIME_W-1:0] ms_nx;
    logic [TIME_W-1:0] limit;
    logic [TIME_W-1:0] limit_nx;
    logic [TIME_W-1:0] mode_limit;
    logic [TIME_W-1:0] res_nx;
    logic              fs_nx;
    logic              to_nx;

    assign start_rise = start & ~start_q;
    assign btn_rise   = btn & ~btn_q;

    always_comb begin
        mode_limit = LIM_HARD;
        case (mode)
            2'd0:    mode_limit = LIM_EASY;
            2'd1:    mode_limit = LIM_MED;
            default: mode_limit = LIM_HARD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        delay_nx = delay_cnt;
        ms_nx    = ms_cnt;
        limit_nx = limit;
        res_nx   = result_ms;
        fs_nx    = false_start;
        to_nx    = timeout;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_nx = ARM;
                    res_nx   = '0;
                    fs_nx    = 1'b0;
                    to_nx    = 1'b0;
                    limit_nx = mode_limit;
                end
            end
            ARM: begin
                if (!btn) begin
                    state_nx = WAIT;
                    delay_nx = DLY_MIN + DLY_W'(lfsr[RAND_W-1:0]);
                end
            end
            WAIT: begin
                // A press always beats delay expiry on the same clk.
                if (btn_rise) begin
                    state_nx = DONE;
                    fs_nx    = 1'b1;
                    res_nx   = '0;
                end else if (tick_1ms) begin
                    delay_nx = delay_cnt - DLY_ONE;
                    if (delay_cnt <= DLY_ONE) begin
                        state_nx = GO;
                        ms_nx    = '0;
                    end
                end
            end
            GO: begin
                // A press beats the timeout, and a tick on the press clk is not counted.
                if (btn_rise) begin
                    state_nx = DONE;
                    res_nx   = ms_cnt;
                end else if (tick_1ms) begin
                    if (ms_cnt == limit - 1'b1) begin
                        state_nx = DONE;
                        to_nx    = 1'b1;
                        res_nx   = limit;
                    end else begin
                        ms_nx = ms_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            btn_q        <= 1'b0;
            lfsr         <= LFSR_SEED;
            delay_cnt    <= '0;
            ms_cnt       <= '0;
            limit        <= '0;
            stim_led     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_ms    <= '0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            start_q      <= start;
            btn_q        <= btn;
            lfsr         <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            delay_cnt    <= delay_nx;
            ms_cnt       <= ms_nx;
            limit        <= limit_nx;
            stim_led     <= (state_nx == GO);
            busy         <= (state_nx != IDLE);
            result_valid <= (state_nx == DONE);
            result_ms    <= res_nx;
            false_start  <= fs_nx;
            timeout      <= to_nx;
        end
    end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb_reaction_round_ctrl: randomized, self-checking bench for reaction_round_ctrl.
// Rounds are driven tick by tick and scored against a ms-level model of the game rules.
module tb_reaction_round_ctrl;

    localparam int          TW   = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick_1ms;
    logic          start;
    logic [1:0]    mode;
    logic          btn;
    logic          stim_led;
    logic          busy;
    logic          result_valid;
    logic [TW-1:0] result_ms;
    logic          false_start;
    logic          timeout;
    logic          result_ack;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;

    reaction_round_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1ms     (tick_1ms),
        .start        (start),
        .mode         (mode),
        .btn          (btn),
        .stim_led     (stim_led),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ms    (result_ms),
        .false_start  (false_start),
        .timeout      (timeout),
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #990000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic int limit_of(input logic [1:0] m);
        case (m)
            2'd0:    return 999;
            2'd1:    return 999 / 2;
            default: return 999 / 4;
        endcase
    endfunction

    // One clk: model LFSR follows the DUT's, then a random tick is set for the next edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) m_lfsr = SEED;
        else        m_lfsr = lfsr_next(m_lfsr);
        #1;
        tick_1ms = ($urandom_range(3) != 0);
    endtask

    // pw: press after pw WAIT ticks (-1 none, -2 on the last delay tick)
    // pg: press after pg GO ticks (-1 none); abort_at: stop in GO after that many ticks
    task automatic play(input logic [1:0] m, input int hold, input int pw,
                        input int pg, input bit align, input bit poke,
                        input int abort_at,
                        output int d_obs, output int d_exp, output int go_ticks,
                        output int hold_busy, output bit led_seen, output bit hung);
        int k;
        int j;
        int g;
        hung = 1'b0;
        led_seen = 1'b0;
        d_obs = -1;
        go_ticks = -1;
        hold_busy = 0;
        mode = m;
        btn = (hold > 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (busy === 1'b1 && stim_led === 1'b0) hold_busy++;
            step();
        end
        btn = 1'b0;
        d_exp = 1000 + int'(m_lfsr[10:0]);
        step();
        mode = 2'($urandom_range(3));
        k = 0;
        g = 0;
        while (stim_led !== 1'b1 && result_valid !== 1'b1 && g < 20000) begin
            if ((pw >= 0 && k == pw) || (pw == -2 && k == d_exp - 1)) begin
                btn = 1'b1;
                if (align) tick_1ms = 1'b1;
            end
            start = (poke && k == 5);
            if (tick_1ms) k++;
            step();
            g++;
        end
        start = 1'b0;
        if (stim_led === 1'b1) begin
            led_seen = 1'b1;
            d_obs = k;
            j = 0;
            while (result_valid !== 1'b1 && g < 20000) begin
                if (abort_at >= 0 && j == abort_at) break;
                if (pg >= 0 && j == pg) begin
                    btn = 1'b1;
                    if (align) tick_1ms = 1'b1;
                end
                start = (poke && j == 3);
                if (tick_1ms) j++;
                step();
                g++;
            end
            go_ticks = j;
        end
        start = 1'b0;
        btn = 1'b0;
        if (abort_at < 0 && result_valid !== 1'b1) hung = 1'b1;
        if (abort_at >= 0 && stim_led !== 1'b1) hung = 1'b1;
    endtask

    task automatic do_ack();
        btn = 1'b0;
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_lfsr = SEED;
        repeat (3) step();
        rst_n = 1'b1;
        checks++; if (stim_led !== 1'b0) begin errors++; $display("FAIL rst_led: got %b want 0", stim_led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", result_valid); end
        checks++; if (result_ms !== '0) begin errors++; $display("FAIL rst_ms: got %0d want 0", result_ms); end
        checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b want 0", false_start); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_to: got %b want 0", timeout); end
    endtask

    task automatic test_react();
        int dobs, dexp, gt, hb;
        bit seen, hung;
        play(2'd0, 0, -1, 237, 1'b0, 1'b0, -1, dobs, dexp, gt, hb, seen, hung);
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL react_hang: got %b want 0", hung); end
        checks++; if (dobs !== dexp) begin errors++; $display("FAIL react_delay: got %0d want %0d", dobs, dexp); end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL react_led: got %b want 1", seen); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL react_valid: got %b want 1", result_valid); end
        checks++; if (result_ms !== TW'(237)) begin errors++; $display("FAIL react_ms: got %0d want 237", result_ms); end
        checks++; if ({false_start, timeout} !== 2'b00) begin errors++; $display("FAIL react_flags: got %b want 00", {false_start, timeout}); end
        checks++; if (stim_led !== 1'b0) begin errors++; $display("FAIL react_led_done: got %b want 0", stim_led); end
        do_ack();
        checks++; if ({busy, result_valid} !== 2'b00) begin errors++; $display("FAIL react_ack: got %b want 00", {busy, result_valid}); end
        checks++; if (result_ms !== TW'(237)) begin errors++; $display("FAIL react_hold: got %0d want 237", result_ms); end
    endtask

    task automatic test_false_start();
        int dobs, dexp, gt, hb, pw;
        bit seen, hung;
        for (int r = 0; r < 2; r++) begin
            pw = (r == 0) ? int'($urandom_range(900)) : -2;
            play(2'($urandom_range(3)), 0, pw, -1, (r == 1), 1'b0, -1,
                 dobs, dexp, gt, hb, seen, hung);
            checks++; if (hung !== 1'b0) begin errors++; $display("FAIL fs_hang%0d: got %b want 0", r, hung); end
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL fs_led%0d: got %b want 0", r, seen); end
            checks++; if (false_start !== 1'b1) begin errors++; $display("FAIL fs_flag%0d: got %b want 1", r, false_start); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL fs_to%0d: got %b want 0", r, timeout); end
            checks++; if (result_ms !== '0) begin errors++; $display("FAIL fs_ms%0d: got %0d want 0", r, result_ms); end
            do_ack();
        end
    endtask

    task automatic test_timeout();
        int dobs, dexp, gt, hb;
        bit seen, hung;
        play(2'd2, 0, -1, -1, 1'b0, 1'b0, -1, dobs, dexp, gt, hb, seen, hung);
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL to_hang: got %b want 0", hung); end
        checks++; if (dobs !== dexp) begin errors++; $display("FAIL to_delay: got %0d want %0d", dobs, dexp); end
        checks++; if (gt !== 249) begin errors++; $display("FAIL to_ticks: got %0d want 249", gt); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout); end
        checks++; if (result_ms !== TW'(249)) begin errors++; $display("FAIL to_ms: got %0d want 249", result_ms); end
        checks++; if (false_start !== 1'b0) begin errors++; $display("FAIL to_fs: got %b want 0", false_start); end
        do_ack();
        checks++; if ({busy, result_valid} !== 2'b00) begin errors++; $display("FAIL to_ack: got %b want 00", {busy, result_valid}); end
    endtask

    task automatic test_hold_arm();
        int dobs, dexp, gt, hb, hold, pg;
        bit seen, hung;
        hold = int'($urandom_range(30, 5));
        pg = int'($urandom_range(498));
        play(2'd1, hold, -1, pg, 1'b0, 1'b0, -1, dobs, dexp, gt, hb, seen, hung);
        checks++; if (hb !== hold) begin errors++; $display("FAIL arm_hold: got %0d want %0d", hb, hold); end
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL arm_hang: got %b want 0", hung); end
        checks++; if (dobs !== dexp) begin errors++; $display("FAIL arm_delay: got %0d want %0d", dobs, dexp); end
        checks++; if (result_ms !== TW'(pg)) begin errors++; $display("FAIL arm_ms: got %0d want %0d", result_ms, pg); end
        do_ack();
    endtask

    task automatic test_press_at_limit();
        int dobs, dexp, gt, hb, lim;
        bit seen, hung;
        logic [1:0] m;
        m = 2'($urandom_range(3));
        lim = limit_of(m);
        play(m, 0, -1, lim - 1, 1'b1, 1'b0, -1, dobs, dexp, gt, hb, seen, hung);
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL lim_hang: got %b want 0", hung); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL lim_to: got %b want 0", timeout); end
        checks++; if (result_ms !== TW'(lim - 1)) begin errors++; $display("FAIL lim_ms: got %0d want %0d", result_ms, lim - 1); end
        do_ack();
    endtask

    task automatic test_reset_mid_go();
        int dobs, dexp, gt, hb;
        bit seen, hung;
        play(2'd0, 0, -1, -1, 1'b0, 1'b0, int'($urandom_range(100, 1)),
             dobs, dexp, gt, hb, seen, hung);
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL mid_reach_go: got %b want 0", hung); end
        rst_n = 1'b0;
        m_lfsr = SEED;
        #1;
        checks++; if (stim_led !== 1'b0) begin errors++; $display("FAIL mid_led: got %b want 0", stim_led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if ({result_valid, false_start, timeout} !== 3'b000) begin errors++; $display("FAIL mid_res: got %b want 000", {result_valid, false_start, timeout}); end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b want 0", busy); end
    endtask

    task automatic test_busy_ignored();
        int dobs, dexp, gt, hb, lim, pg, held;
        bit seen, hung;
        logic [1:0] m;
        m = 2'($urandom_range(3));
        lim = limit_of(m);
        pg = int'($urandom_range(lim - 1, 10));
        play(m, 0, -1, pg, 1'b0, 1'b1, -1, dobs, dexp, gt, hb, seen, hung);
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL ign_hang: got %b want 0", hung); end
        checks++; if (dobs !== dexp) begin errors++; $display("FAIL ign_delay: got %0d want %0d", dobs, dexp); end
        checks++; if (result_ms !== TW'(pg)) begin errors++; $display("FAIL ign_ms: got %0d want %0d", result_ms, pg); end
        held = 0;
        for (int i = 0; i < 40; i++) begin
            start = (i >= 10 && i < 12);
            step();
            if (result_valid === 1'b1 && busy === 1'b1 && result_ms === TW'(pg)
                && {false_start, timeout} === 2'b00) held++;
        end
        start = 1'b0;
        checks++; if (held !== 40) begin errors++; $display("FAIL ign_held: got %0d want 40", held); end
        do_ack();
        checks++; if ({busy, result_valid} !== 2'b00) begin errors++; $display("FAIL ign_ack: got %b want 00", {busy, result_valid}); end
    endtask

    task automatic test_random_rounds();
        int dobs, dexp, gt, hb, lim, pw, pg, kind, e_ms;
        bit seen, hung, e_fs, e_to;
        logic [1:0] m;
        for (int r = 0; r < 3; r++) begin
            m = 2'($urandom_range(3));
            lim = limit_of(m);
            kind = int'($urandom_range(2));
            pw = -1;
            pg = -1;
            if (kind == 0) pw = int'($urandom_range(900));
            if (kind == 1) pg = int'($urandom_range(lim + 50));
            if (kind == 0) begin
                e_ms = 0; e_fs = 1'b1; e_to = 1'b0;
            end else if (pg >= 0 && pg < lim) begin
                e_ms = pg; e_fs = 1'b0; e_to = 1'b0;
            end else begin
                e_ms = lim; e_fs = 1'b0; e_to = 1'b1;
            end
            play(m, int'($urandom_range(3)), pw, pg, bit'($urandom_range(1)), 1'b0, -1,
                 dobs, dexp, gt, hb, seen, hung);
            checks++; if (hung !== 1'b0) begin errors++; $display("FAIL rnd%0d_hang: got %b want 0", r, hung); end
            if (kind != 0) begin
                checks++; if (dobs !== dexp) begin errors++; $display("FAIL rnd%0d_delay: got %0d want %0d", r, dobs, dexp); end
            end
            checks++; if (result_ms !== TW'(e_ms)) begin errors++; $display("FAIL rnd%0d_ms: got %0d want %0d", r, result_ms, e_ms); end
            checks++; if ({false_start, timeout} !== {e_fs, e_to}) begin errors++; $display("FAIL rnd%0d_flags: got %b want %b", r, {false_start, timeout}, {e_fs, e_to}); end
            do_ack();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick_1ms = 1'b0;
        start = 1'b0;
        mode = 2'd0;
        btn = 1'b0;
        result_ack = 1'b0;
        m_lfsr = SEED;
        test_reset();
        test_react();
        test_false_start();
        test_timeout();
        test_hold_arm();
        test_press_at_limit();
        test_reset_mid_go();
        test_busy_ignored();
        test_random_rounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
